paillier_keygen_ctrl: RTL and testbench
=======================================

// Module: paillier_keygen_ctrl
// PURPOSE
//  Sequences Paillier key derivation from primes p,q over one shared GCD/LCM engine.
//  Computes n=p*q and phi=(p-1)(q-1) locally, checks gcd(n,phi)==1 on the engine,
//  then obtains lambda=lcm(p-1,q-1) from the engine.
//  Sits between the key-setup host logic and the gcd/lcm arithmetic unit.
// PARAMETERS
//  PW       16  prime operand width; engine/result width EW=2*PW (localparam)
//  TIMEOUT  1024 max cycles waited for eng_done per engine request (>=2)
// PORTS
//  clk         in   1     clock; all logic on posedge
//  rst         in   1     reset; one clock, synchronous, active-high
//  start       in   1     request keygen; accepted only when busy=0
//  p_in        in   PW    prime p, sampled on accepted start
//  q_in        in   PW    prime q, sampled on accepted start
//  busy        out  1     high from cycle after accepted start until done pulse
//  done        out  1     one-cycle completion pulse
//  err_code    out  2     0 OK, 1 bad input, 2 not coprime, 3 engine timeout
//  n_out       out  EW    p*q
//  lambda_out  out  EW    lcm(p-1,q-1); 0 when err_code!=0
//  eng_start   out  1     one-cycle engine request pulse
//  eng_op      out  1     0 GCD, 1 LCM; held stable until eng_done or timeout
//  eng_a       out  EW    operand A, held stable while waiting
//  eng_b       out  EW    operand B, held stable while waiting
//  eng_result  in   EW    engine result, valid when eng_done=1
//  eng_done    in   1     engine completion strobe
// BEHAVIOUR
//  Reset: state IDLE; busy,done,eng_start,eng_op=0; err_code,n_out,lambda_out,eng_a,eng_b=0.
//  FSM: IDLE -start-> PREP -> GCD_REQ -> GCD_WAIT -> LCM_REQ -> LCM_WAIT -> DONE -> IDLE.
//  IDLE: start captures p,q; start while busy=1 ignored (no queueing).
//  PREP (1 cycle): if p<2, q<2 or p==q -> err=1, go DONE; else register n=p*q, phi (EW bits, no overflow).
//  GCD_REQ: eng_start=1, op=0, a=n, b=phi; clear timer; -> GCD_WAIT.
//  GCD_WAIT: eng_done & result==1 -> LCM_REQ; eng_done & result!=1 -> err=2, DONE.
//  LCM_REQ: eng_start=1, op=1, a=p-1, b=q-1 (zero-extended); -> LCM_WAIT.
//  LCM_WAIT: eng_done -> lambda_out<=eng_result, err=0, DONE.
//  Timer: counts wait cycles; reaching TIMEOUT without eng_done -> err=3, DONE.
//  eng_done and timeout in same cycle: eng_done wins.
//  eng_done outside *_WAIT states ignored.
//  DONE: done=1 for exactly one cycle, busy drops same cycle; -> IDLE.
//  n_out, err_code, lambda_out hold from DONE until next accepted start (cleared then).
//  Latency (OK path): done asserted 1 cycle after LCM eng_done sampled;
//   start at T0 -> eng_start (GCD) at T0+3.
//  rst mid-operation: abort to IDLE, all outputs to reset values; engine shares rst.
// CONFIGURATION
//  PAILLIER_KG_NSQ_EN defined: extra port nsq_out out 2*EW = n*n, registered in
//   an extra NSQ state between PREP and GCD_REQ (+1 cycle latency); reset 0,
//   held like n_out; 0 on err=1.
//  Undefined: no nsq_out port, no NSQ state, latency as above.
// STRUCTURE
//  paillier_pkg: state enum kg_state_t, ERR_OK/ERR_INPUT/ERR_COPRIME/ERR_TIMEOUT,
//   OP_GCD/OP_LCM encodings.
//  One sub-module: kg_timeout_counter (clear, enable, TIMEOUT param, expired flag).
//  Multiplies are local combinational feeding registers; no division in this block.
// TESTING
//  p=11,q=13, engine model 5-cycle latency -> n=143, lambda=60, err=0, one done pulse.
//  p=7,q=7 and p=1,q=13 -> err=1, done 2 cycles after start, no eng_start ever.
//  p=3,q=7 -> engine GCD(21,12)=3 -> err=2, lambda=0, no LCM request issued.
//  TIMEOUT=16, engine silent -> err=3 after 16 wait cycles; late eng_done ignored.
//  start pulsed while busy; rst asserted in GCD_WAIT -> second start ignored; IDLE, outputs 0.
//  PAILLIER_KG_NSQ_EN, p=11,q=13 -> nsq_out=20449, latency +1 cycle vs base build.

Source files
------------

// File: rtl/paillier_pkg.sv
// Shared types and encodings for the Paillier key-generation controller.
package paillier_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_NSQ,
    ST_GCD_REQ,
    ST_GCD_WAIT,
    ST_LCM_REQ,
    ST_LCM_WAIT,
    ST_DONE
  } kg_state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_INPUT   = 2'd1;
  localparam logic [1:0] ERR_COPRIME = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic OP_GCD = 1'b0;
  localparam logic OP_LCM = 1'b1;

  // busy covers every state between accepting start and the done pulse
  function automatic logic is_busy_state(input kg_state_t s);
    return !((s == ST_IDLE) || (s == ST_DONE));
  endfunction

endpackage

// File: rtl/kg_timeout_counter.sv
// Wait-cycle counter for engine requests; expired flags the TIMEOUT-th enabled cycle.
module kg_timeout_counter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/paillier_keygen_ctrl.sv
// Paillier key-derivation sequencer: n, phi locally, gcd/lcm on a shared engine.
// Optional macro PAILLIER_KG_NSQ_EN adds nsq_out = n*n via an extra NSQ state.
module paillier_keygen_ctrl
  import paillier_pkg::*;
#(
  parameter int unsigned PW      = 16,
  parameter int unsigned TIMEOUT = 1024,
  localparam int unsigned EW     = 2 * PW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [PW-1:0] p_in,
  input  logic [PW-1:0] q_in,
  output logic          busy,
  output logic          done,
  output logic [1:0]    err_code,
  output logic [EW-1:0] n_out,
  output logic [EW-1:0] lambda_out,
  output logic          eng_start,
  output logic          eng_op,
  output logic [EW-1:0] eng_a,
  output logic [EW-1:0] eng_b,
  input  logic [EW-1:0] eng_result,
  input  logic          eng_done
`ifdef PAILLIER_KG_NSQ_EN
  ,
  output logic [2*EW-1:0] nsq_out
`endif
);

  kg_state_t     state_q, state_d;
  logic [PW-1:0] p_q, p_d, q_q, q_d;
  logic [EW-1:0] n_q, n_d, phi_q, phi_d, lambda_q, lambda_d;
  logic [EW-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]    err_q, err_d;
  logic          op_q, op_d;
  logic          eng_start_q, eng_start_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          tmr_clear, tmr_en, tmr_expired;
`ifdef PAILLIER_KG_NSQ_EN
  logic [2*EW-1:0] nsq_q, nsq_d;
`endif

  logic [EW-1:0] p_ext, q_ext, pm1_ext, qm1_ext, n_prod, phi_prod;
  logic          bad_input;

  assign p_ext     = {{PW{1'b0}}, p_q};
  assign q_ext     = {{PW{1'b0}}, q_q};
  assign pm1_ext   = p_ext - EW'(1);
  assign qm1_ext   = q_ext - EW'(1);
  assign n_prod    = p_ext * q_ext;
  assign phi_prod  = pm1_ext * qm1_ext;
  assign bad_input = (p_q < PW'(2)) || (q_q < PW'(2)) || (p_q == q_q);

  kg_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    q_d         = q_q;
    n_d         = n_q;
    phi_d       = phi_q;
    lambda_d    = lambda_q;
    a_d         = a_q;
    b_d         = b_q;
    err_d       = err_q;
    op_d        = op_q;
    eng_start_d = 1'b0;
    tmr_clear   = 1'b0;
    tmr_en      = 1'b0;
`ifdef PAILLIER_KG_NSQ_EN
    nsq_d       = nsq_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          p_d      = p_in;
          q_d      = q_in;
          n_d      = '0;
          lambda_d = '0;
          err_d    = ERR_OK;
`ifdef PAILLIER_KG_NSQ_EN
          nsq_d    = '0;
`endif
          state_d  = ST_PREP;
        end
      end
      ST_PREP: begin
        if (bad_input) begin
          err_d   = ERR_INPUT;
          state_d = ST_DONE;
        end else begin
          n_d   = n_prod;
          phi_d = phi_prod;
`ifdef PAILLIER_KG_NSQ_EN
          state_d = ST_NSQ;
`else
          state_d = ST_GCD_REQ;
`endif
        end
      end
`ifdef PAILLIER_KG_NSQ_EN
      ST_NSQ: begin
        nsq_d   = {{EW{1'b0}}, n_q} * {{EW{1'b0}}, n_q};
        state_d = ST_GCD_REQ;
      end
`endif
      ST_GCD_REQ: begin
        eng_start_d = 1'b1;
        op_d        = OP_GCD;
        a_d         = n_q;
        b_d         = phi_q;
        tmr_clear   = 1'b1;
        state_d     = ST_GCD_WAIT;
      end
      ST_GCD_WAIT: begin
        tmr_en = 1'b1;
        // eng_done takes priority over a same-cycle timeout
        if (eng_done) begin
          if (eng_result == EW'(1)) begin
            state_d = ST_LCM_REQ;
          end else begin
            err_d   = ERR_COPRIME;
            state_d = ST_DONE;
          end
        end else if (tmr_expired) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_DONE;
        end
      end
      ST_LCM_REQ: begin
        eng_start_d = 1'b1;
        op_d        = OP_LCM;
        a_d         = pm1_ext;
        b_d         = qm1_ext;
        tmr_clear   = 1'b1;
        state_d     = ST_LCM_WAIT;
      end
      ST_LCM_WAIT: begin
        tmr_en = 1'b1;
        if (eng_done) begin
          lambda_d = eng_result;
          err_d    = ERR_OK;
          state_d  = ST_DONE;
        end else if (tmr_expired) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = is_busy_state(state_d);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      p_q         <= '0;
      q_q         <= '0;
      n_q         <= '0;
      phi_q       <= '0;
      lambda_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      err_q       <= ERR_OK;
      op_q        <= OP_GCD;
      eng_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef PAILLIER_KG_NSQ_EN
      nsq_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      q_q         <= q_d;
      n_q         <= n_d;
      phi_q       <= phi_d;
      lambda_q    <= lambda_d;
      a_q         <= a_d;
      b_q         <= b_d;
      err_q       <= err_d;
      op_q        <= op_d;
      eng_start_q <= eng_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef PAILLIER_KG_NSQ_EN
      nsq_q       <= nsq_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err_code   = err_q;
  assign n_out      = n_q;
  assign lambda_out = lambda_q;
  assign eng_start  = eng_start_q;
  assign eng_op     = op_q;
  assign eng_a      = a_q;
  assign eng_b      = b_q;
`ifdef PAILLIER_KG_NSQ_EN
  assign nsq_out    = nsq_q;
`endif

endmodule

// File: tb/tb_paillier_keygen_ctrl.sv
// Directed bench for paillier_keygen_ctrl; bench drives the engine handshake by hand.
module tb_paillier_keygen_ctrl;

  localparam int unsigned PW = 16;
  localparam int unsigned EW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [PW-1:0] p_in = '0;
  logic [PW-1:0] q_in = '0;
  logic          busy, done;
  logic [1:0]    err_code;
  logic [EW-1:0] n_out, lambda_out;
  logic          eng_start, eng_op;
  logic [EW-1:0] eng_a, eng_b;
  logic [EW-1:0] eng_result = '0;
  logic          eng_done = 1'b0;
`ifdef PAILLIER_KG_NSQ_EN
  logic [2*EW-1:0] nsq_out;
`endif

  int total = 0;
  int bad   = 0;
  int es_cnt = 0;
  int done_cnt = 0;

  paillier_keygen_ctrl #(
    .PW      (16),
    .TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .p_in       (p_in),
    .q_in       (q_in),
    .busy       (busy),
    .done       (done),
    .err_code   (err_code),
    .n_out      (n_out),
    .lambda_out (lambda_out),
    .eng_start  (eng_start),
    .eng_op     (eng_op),
    .eng_a      (eng_a),
    .eng_b      (eng_b),
    .eng_result (eng_result),
    .eng_done   (eng_done)
`ifdef PAILLIER_KG_NSQ_EN
    ,
    .nsq_out    (nsq_out)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (eng_start === 1'b1) es_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [PW-1:0] p, input logic [PW-1:0] q);
    p_in  = p;
    q_in  = q;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_eng_start(output int n);
    n = 0;
    while (eng_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic engine_reply(input logic [EW-1:0] res, input int lat);
    repeat (lat - 1) tick();
    eng_result = res;
    eng_done   = 1'b1;
    tick();
    eng_done   = 1'b0;
    eng_result = '0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int es0, dn0;
    int exp_lat;
`ifdef PAILLIER_KG_NSQ_EN
    exp_lat = 3;
`else
    exp_lat = 2;
`endif

    // reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_code, 0);
    check("rst_n", n_out, 0);
    check("rst_lambda", lambda_out, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_op", eng_op, 0);
    check("rst_eng_a", eng_a, 0);
    check("rst_eng_b", eng_b, 0);
`ifdef PAILLIER_KG_NSQ_EN
    check("rst_nsq", nsq_out, 0);
`endif

    // OK path p=11 q=13: n=143, phi=120, gcd=1, lcm(10,12)=60
    es0 = es_cnt; dn0 = done_cnt;
    do_start(16'd11, 16'd13);
    check("ok_busy", busy, 1);
    wait_eng_start(n);
    check("ok_gcd_latency", n, exp_lat);
    check("ok_gcd_op", eng_op, 0);
    check("ok_gcd_a", eng_a, 143);
    check("ok_gcd_b", eng_b, 120);
    engine_reply(32'd1, 5);
    wait_eng_start(n);
    check("ok_lcm_latency", n, 1);
    check("ok_lcm_op", eng_op, 1);
    check("ok_lcm_a", eng_a, 10);
    check("ok_lcm_b", eng_b, 12);
    engine_reply(32'd60, 5);
    check("ok_done", done, 1);
    check("ok_busy_drop", busy, 0);
    check("ok_err", err_code, 0);
    check("ok_n", n_out, 143);
    check("ok_lambda", lambda_out, 60);
`ifdef PAILLIER_KG_NSQ_EN
    check("ok_nsq", nsq_out, 20449);
`endif
    tick();
    check("ok_done_pulse", done, 0);
    check("ok_n_hold", n_out, 143);
    check("ok_lambda_hold", lambda_out, 60);
    tick(); tick();
    check("ok_done_count", done_cnt - dn0, 1);
    check("ok_eng_start_count", es_cnt - es0, 2);

    // bad input p==q
    es0 = es_cnt;
    do_start(16'd7, 16'd7);
    tick();
    check("eq_done", done, 1);
    check("eq_err", err_code, 1);
    check("eq_n", n_out, 0);
    check("eq_lambda", lambda_out, 0);
`ifdef PAILLIER_KG_NSQ_EN
    check("eq_nsq", nsq_out, 0);
`endif
    tick(); tick();
    check("eq_no_eng", es_cnt - es0, 0);

    // bad input p<2
    es0 = es_cnt;
    do_start(16'd1, 16'd13);
    tick();
    check("small_done", done, 1);
    check("small_err", err_code, 1);
    tick(); tick();
    check("small_no_eng", es_cnt - es0, 0);

    // not coprime p=3 q=7: gcd(21,12)=3
    es0 = es_cnt;
    do_start(16'd3, 16'd7);
    wait_eng_start(n);
    check("nc_gcd_a", eng_a, 21);
    check("nc_gcd_b", eng_b, 12);
    engine_reply(32'd3, 5);
    check("nc_done", done, 1);
    check("nc_err", err_code, 2);
    check("nc_lambda", lambda_out, 0);
    tick(); tick(); tick();
    check("nc_no_lcm", es_cnt - es0, 1);

    // timeout: engine silent, p=5 q=7
    dn0 = done_cnt;
    do_start(16'd5, 16'd7);
    wait_eng_start(n);
    check("to_gcd_a", eng_a, 35);
    wait_done(n);
    check("to_wait_cycles", n, 16);
    check("to_err", err_code, 3);
    check("to_lambda", lambda_out, 0);
    tick();
    es0 = es_cnt;
    eng_result = 32'd1;
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    eng_result = '0;
    tick(); tick();
    check("late_busy", busy, 0);
    check("late_err_hold", err_code, 3);
    check("late_no_eng", es_cnt - es0, 0);
    check("late_done_count", done_cnt - dn0, 1);

    // start while busy ignored, then rst in GCD_WAIT
    do_start(16'd11, 16'd13);
    wait_eng_start(n);
    tick();
    do_start(16'd3, 16'd7);
    check("ign_busy", busy, 1);
    check("ign_eng_a", eng_a, 143);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_err", err_code, 0);
    check("mrst_n", n_out, 0);
    check("mrst_eng_a", eng_a, 0);
    check("mrst_eng_op", eng_op, 0);
    tick(); tick();
    check("mrst_idle", busy, 0);

    // restart after reset, p=5 q=7: lcm(4,6)=12
    do_start(16'd5, 16'd7);
    wait_eng_start(n);
    check("rs_gcd_b", eng_b, 24);
    engine_reply(32'd1, 3);
    wait_eng_start(n);
    check("rs_lcm_a", eng_a, 4);
    check("rs_lcm_b", eng_b, 6);
    engine_reply(32'd12, 3);
    check("rs_done", done, 1);
    check("rs_n", n_out, 35);
    check("rs_lambda", lambda_out, 12);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
